// File: rtl/lsu_stage_if.sv
// Data-memory port of the LSU: req/gnt/rvalid handshake with write strobes.
// The master modport faces the LSU and the slave modport faces the memory.
interface lsu_stage_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_stage.sv
// RV32I memory stage: issues loads/stores on a req/gnt/rvalid port and drives writeback.
// Define LSU_MISALIGN_TRAP_EN to drop misaligned H/W accesses and pulse lsu_misalign.
module lsu_stage #(
  parameter int AW = 32
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        alu_vld,
  input  logic        alu_flush,
  input  logic [3:0]  alu_LS,
  input  logic        alu_ld_unsigned,
  input  logic [4:0]  alu_rd,
  input  logic        alu_rd_wen,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_rs2_data,
  output logic        lsu_busy,
  lsu_stage_if.master mem,
  output logic        lsu_mem_rvld,
  output logic [4:0]  wb_rd,
  output logic        wb_rd_wen,
  output logic [31:0] wb_rd_data,
  output logic        lsu_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [4:0]    rd_q, rd_d;
  logic          rdwen_q, rdwen_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lo_q, lo_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          wb_wen_q, wb_wen_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          rvld_q, rvld_d;

  logic          accept;
  logic [1:0]    lo_eff;
  logic [3:0]    strb_new;
  logic [31:0]   wdata_new;
  logic [31:0]   rshift;
  logic [31:0]   load_data;

  assign accept = alu_vld & ~alu_flush & (state_q == IDLE);

  // Low address bits snapped to natural alignment for the access size
  always_comb begin
    unique case (alu_LS[1:0])
      2'b00:   lo_eff = alu_out[1:0];
      2'b01:   lo_eff = {alu_out[1], 1'b0};
      default: lo_eff = 2'b00;
    endcase
  end

  always_comb begin
    unique case (alu_LS[1:0])
      2'b00: begin
        strb_new  = 4'b0001 << lo_eff;
        wdata_new = {4{alu_rs2_data[7:0]}};
      end
      2'b01: begin
        strb_new  = 4'b0011 << {lo_eff[1], 1'b0};
        wdata_new = {2{alu_rs2_data[15:0]}};
      end
      default: begin
        strb_new  = 4'hF;
        wdata_new = alu_rs2_data;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q, misalign_d;
  assign misaligned = ((alu_LS[1:0] == 2'b01) & alu_out[0]) |
                      (alu_LS[1] & (alu_out[1:0] != 2'b00));
  assign lsu_misalign = misalign_q;
`else
  assign lsu_misalign = 1'b0;
`endif

  // Halfword offsets are always even, so a byte-granular shift serves both sizes
  assign rshift = mem.mem_rdata >> {lo_q, 3'b000};

  always_comb begin
    unique case (size_q)
      2'b00:   load_data = {{24{~uns_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_data = {{16{~uns_q & rshift[15]}}, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rd_d      = rd_q;
    rdwen_d   = rdwen_q;
    size_d    = size_q;
    uns_d     = uns_q;
    lo_d      = lo_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_wen_d  = 1'b0;
    rvld_d    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!alu_LS[3]) begin
            wb_rd_d   = alu_rd;
            wb_wen_d  = alu_rd_wen;
            wb_data_d = alu_out;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misaligned) begin
            misalign_d = 1'b1;
          end
`endif
          else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = alu_LS[2];
            addr_d  = {alu_out[AW-1:2], 2'b00};
            wdata_d = wdata_new;
            wstrb_d = alu_LS[2] ? strb_new : 4'b0000;
            rd_d    = alu_rd;
            rdwen_d = alu_rd_wen;
            size_d  = alu_LS[1:0];
            uns_d   = alu_ld_unsigned;
            lo_d    = lo_eff;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          state_d = we_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          state_d   = IDLE;
          wb_rd_d   = rd_q;
          wb_wen_d  = rdwen_q;
          wb_data_d = load_data;
          rvld_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_q      <= '0;
      rdwen_q   <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      lo_q      <= '0;
      wb_rd_q   <= '0;
      wb_wen_q  <= 1'b0;
      wb_data_q <= '0;
      rvld_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rd_q      <= rd_d;
      rdwen_q   <= rdwen_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      lo_q      <= lo_d;
      wb_rd_q   <= wb_rd_d;
      wb_wen_q  <= wb_wen_d;
      wb_data_q <= wb_data_d;
      rvld_q    <= rvld_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign lsu_busy      = (state_q != IDLE);
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
  assign lsu_mem_rvld  = rvld_q;
  assign wb_rd         = wb_rd_q;
  assign wb_rd_wen     = wb_wen_q;
  assign wb_rd_data    = wb_data_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: vector table for passthrough ops plus
// hand-written load/store/reset/misalign sequences with a scripted memory.
module tb_lsu_stage;

  logic        CLK;
  logic        RSTN;
  logic        alu_vld;
  logic        alu_flush;
  logic [3:0]  alu_LS;
  logic        alu_ld_unsigned;
  logic [4:0]  alu_rd;
  logic        alu_rd_wen;
  logic [31:0] alu_out;
  logic [31:0] alu_rs2_data;
  logic        lsu_busy;
  logic        lsu_mem_rvld;
  logic [4:0]  wb_rd;
  logic        wb_rd_wen;
  logic [31:0] wb_rd_data;
  logic        lsu_misalign;

  int n_chk  = 0;
  int n_fail = 0;

  lsu_stage_if #(.AW(32)) mem_if ();

  lsu_stage #(.AW(32)) dut (
    .CLK             (CLK),
    .RSTN            (RSTN),
    .alu_vld         (alu_vld),
    .alu_flush       (alu_flush),
    .alu_LS          (alu_LS),
    .alu_ld_unsigned (alu_ld_unsigned),
    .alu_rd          (alu_rd),
    .alu_rd_wen      (alu_rd_wen),
    .alu_out         (alu_out),
    .alu_rs2_data    (alu_rs2_data),
    .lsu_busy        (lsu_busy),
    .mem             (mem_if),
    .lsu_mem_rvld    (lsu_mem_rvld),
    .wb_rd           (wb_rd),
    .wb_rd_wen       (wb_rd_wen),
    .wb_rd_data      (wb_rd_data),
    .lsu_misalign    (lsu_misalign)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance one edge; all driving and sampling happens 1ns after posedge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    alu_vld = 1'b0; alu_flush = 1'b0; alu_LS = 4'h0; alu_ld_unsigned = 1'b0;
    alu_rd = 5'd0; alu_rd_wen = 1'b0; alu_out = 32'h0; alu_rs2_data = 32'h0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_req"},   32'(mem_if.mem_req),   32'h0);
    chk({nm, "_we"},    32'(mem_if.mem_we),    32'h0);
    chk({nm, "_addr"},  mem_if.mem_addr,       32'h0);
    chk({nm, "_wdata"}, mem_if.mem_wdata,      32'h0);
    chk({nm, "_wstrb"}, 32'(mem_if.mem_wstrb), 32'h0);
    chk({nm, "_busy"},  32'(lsu_busy),         32'h0);
    chk({nm, "_rvld"},  32'(lsu_mem_rvld),     32'h0);
    chk({nm, "_wbrd"},  32'(wb_rd),            32'h0);
    chk({nm, "_wen"},   32'(wb_rd_wen),        32'h0);
    chk({nm, "_wdat"},  wb_rd_data,            32'h0);
    chk({nm, "_mis"},   32'(lsu_misalign),     32'h0);
  endtask

  task automatic do_load(input string nm, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [4:0] rd, input int gnt_wait,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data);
    alu_vld = 1'b1; alu_LS = {2'b10, size}; alu_ld_unsigned = uns;
    alu_rd = rd; alu_rd_wen = 1'b1; alu_out = addr;
    tick();
    idle_inputs();
    chk({nm, "_req"},  32'(mem_if.mem_req),   32'h1);
    chk({nm, "_we"},   32'(mem_if.mem_we),    32'h0);
    chk({nm, "_strb"}, 32'(mem_if.mem_wstrb), 32'h0);
    chk({nm, "_addr"}, mem_if.mem_addr,       exp_addr);
    chk({nm, "_busy"}, 32'(lsu_busy),         32'h1);
    for (int i = 0; i < gnt_wait; i++) begin
      tick();
      chk({nm, "_req_hold"},  32'(mem_if.mem_req), 32'h1);
      chk({nm, "_addr_hold"}, mem_if.mem_addr,     exp_addr);
    end
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    chk({nm, "_req_drop"}, 32'(mem_if.mem_req), 32'h0);
    chk({nm, "_busy_w"},   32'(lsu_busy),       32'h1);
    tick();
    chk({nm, "_rvld_pre"}, 32'(lsu_mem_rvld), 32'h0);
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = rdata;
    tick();
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = 32'h0;
    chk({nm, "_rvld"}, 32'(lsu_mem_rvld), 32'h1);
    chk({nm, "_wen"},  32'(wb_rd_wen),    32'h1);
    chk({nm, "_rd"},   32'(wb_rd),        32'(rd));
    chk({nm, "_data"}, wb_rd_data,        exp_data);
    chk({nm, "_busy"}, 32'(lsu_busy),     32'h0);
    $display("load  %s addr=%h rdata=%h -> wb_rd=%0d data=%h", nm, addr, rdata, wb_rd, wb_rd_data);
    tick();
    chk({nm, "_rvld_off"}, 32'(lsu_mem_rvld), 32'h0);
    chk({nm, "_wen_off"},  32'(wb_rd_wen),    32'h0);
  endtask

  task automatic do_store(input string nm, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] rs2, input int gnt_wait, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    alu_vld = 1'b1; alu_LS = {2'b11, size}; alu_rd = 5'd12; alu_rd_wen = 1'b1;
    alu_out = addr; alu_rs2_data = rs2;
    tick();
    idle_inputs();
    chk({nm, "_req"},   32'(mem_if.mem_req),   32'h1);
    chk({nm, "_we"},    32'(mem_if.mem_we),    32'h1);
    chk({nm, "_addr"},  mem_if.mem_addr,       exp_addr);
    chk({nm, "_strb"},  32'(mem_if.mem_wstrb), 32'(exp_strb));
    chk({nm, "_wdata"}, mem_if.mem_wdata,      exp_wdata);
    for (int i = 0; i < gnt_wait; i++) begin
      tick();
      chk({nm, "_req_hold"},  32'(mem_if.mem_req),   32'h1);
      chk({nm, "_strb_hold"}, 32'(mem_if.mem_wstrb), 32'(exp_strb));
      chk({nm, "_wen_none"},  32'(wb_rd_wen),        32'h0);
    end
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    chk({nm, "_busy_clr"}, 32'(lsu_busy),       32'h0);
    chk({nm, "_req_drop"}, 32'(mem_if.mem_req), 32'h0);
    chk({nm, "_wen"},      32'(wb_rd_wen),      32'h0);
    chk({nm, "_rvld"},     32'(lsu_mem_rvld),   32'h0);
    $display("store %s addr=%h rs2=%h strb=%b wdata=%h", nm, addr, rs2, exp_strb, exp_wdata);
  endtask

  typedef struct {
    string       nm;
    logic        vld;
    logic        flush;
    logic [3:0]  ls;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] out;
    logic        exp_wen;
    logic        chk_wb;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"add",        1'b1, 1'b0, 4'h0, 5'd5,  1'b1, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_1234};
    vecs[1] = '{"bubble",     1'b0, 1'b0, 4'h0, 5'd6,  1'b1, 32'h0000_0099, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{"x0_pass",    1'b1, 1'b0, 4'h0, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{"nowen",      1'b1, 1'b0, 4'h0, 5'd31, 1'b0, 32'hCAFE_0001, 1'b0, 1'b1, 32'hCAFE_0001};
    vecs[4] = '{"flush_alu",  1'b1, 1'b1, 4'h0, 5'd7,  1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{"flush_mem",  1'b1, 1'b1, 4'hA, 5'd8,  1'b1, 32'h0000_4000, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{"bit2_nomem", 1'b1, 1'b0, 4'h4, 5'd9,  1'b1, 32'h0000_0077, 1'b1, 1'b1, 32'h0000_0077};

    idle_inputs();
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
    RSTN = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    $display("reset state checked");
    RSTN = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      alu_vld = vecs[i].vld; alu_flush = vecs[i].flush; alu_LS = vecs[i].ls;
      alu_rd = vecs[i].rd; alu_rd_wen = vecs[i].wen; alu_out = vecs[i].out;
      tick();
      idle_inputs();
      chk({vecs[i].nm, "_wen"},  32'(wb_rd_wen),      32'(vecs[i].exp_wen));
      chk({vecs[i].nm, "_busy"}, 32'(lsu_busy),       32'h0);
      chk({vecs[i].nm, "_req"},  32'(mem_if.mem_req), 32'h0);
      chk({vecs[i].nm, "_rvld"}, 32'(lsu_mem_rvld),   32'h0);
      if (vecs[i].chk_wb) begin
        chk({vecs[i].nm, "_rd"},   32'(wb_rd),   32'(vecs[i].rd));
        chk({vecs[i].nm, "_data"}, wb_rd_data,   vecs[i].exp_data);
      end
      $display("vec   %s -> wb_rd=%0d wen=%0b data=%h", vecs[i].nm, wb_rd, wb_rd_wen, wb_rd_data);
    end

    do_load("lb",  2'b00, 1'b0, 32'h0000_1003, 5'd1, 2, 32'h80FF_FF7F, 32'h0000_1000, 32'hFFFF_FF80);
    do_load("lbu", 2'b00, 1'b1, 32'h0000_1003, 5'd2, 0, 32'h80FF_FF7F, 32'h0000_1000, 32'h0000_0080);
    do_load("lb0", 2'b00, 1'b0, 32'h0000_1000, 5'd2, 1, 32'h80FF_FF7F, 32'h0000_1000, 32'h0000_007F);
    do_load("lh",  2'b01, 1'b0, 32'h0000_1002, 5'd3, 1, 32'h80FF_FF7F, 32'h0000_1000, 32'hFFFF_80FF);
    do_load("lhu", 2'b01, 1'b1, 32'h0000_1000, 5'd4, 0, 32'h80FF_FF7F, 32'h0000_1000, 32'h0000_FF7F);
    do_load("lw",  2'b10, 1'b0, 32'h0000_2004, 5'd5, 1, 32'h1234_5678, 32'h0000_2004, 32'h1234_5678);

    do_store("sh", 2'b01, 32'h0000_2002, 32'hAAAA_BEEF, 1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    do_store("sb", 2'b00, 32'h0000_3001, 32'h1234_5678, 0, 32'h0000_3000, 4'b0010, 32'h7878_7878);
    do_store("sw", 2'b10, 32'h0000_4000, 32'hDEAD_BEEF, 2, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF);

    // Second op held on alu_vld while a load is in flight
    alu_vld = 1'b1; alu_LS = 4'hA; alu_rd = 5'd3; alu_rd_wen = 1'b1; alu_out = 32'h0000_5000;
    tick();
    alu_LS = 4'h0; alu_rd = 5'd6; alu_out = 32'h0000_0066;
    chk("b2b_busy", 32'(lsu_busy), 32'h1);
    chk("b2b_wen0", 32'(wb_rd_wen), 32'h0);
    tick();
    chk("b2b_wen1", 32'(wb_rd_wen), 32'h0);
    chk("b2b_req",  32'(mem_if.mem_req), 32'h1);
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    chk("b2b_wen2", 32'(wb_rd_wen), 32'h0);
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
    chk("b2b_ld_rvld", 32'(lsu_mem_rvld), 32'h1);
    chk("b2b_ld_rd",   32'(wb_rd),        32'd3);
    chk("b2b_ld_data", wb_rd_data,        32'h0BAD_F00D);
    tick();
    idle_inputs();
    chk("b2b_add_wen",  32'(wb_rd_wen),    32'h1);
    chk("b2b_add_rd",   32'(wb_rd),        32'd6);
    chk("b2b_add_data", wb_rd_data,        32'h0000_0066);
    chk("b2b_add_rvld", 32'(lsu_mem_rvld), 32'h0);
    $display("b2b   load then held add -> wb_rd=%0d data=%h", wb_rd, wb_rd_data);
    tick();
    chk("b2b_after", 32'(wb_rd_wen), 32'h0);

    // Stray handshakes while IDLE
    mem_if.mem_gnt = 1'b1; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
    chk("stray_busy", 32'(lsu_busy),     32'h0);
    chk("stray_rvld", 32'(lsu_mem_rvld), 32'h0);
    chk("stray_wen",  32'(wb_rd_wen),    32'h0);
    $display("stray gnt/rvalid in IDLE ignored");

    // Reset while waiting for read data
    alu_vld = 1'b1; alu_LS = 4'hA; alu_rd = 5'd4; alu_rd_wen = 1'b1; alu_out = 32'h0000_6000;
    tick();
    idle_inputs();
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    chk("rst_pre_busy", 32'(lsu_busy), 32'h1);
    RSTN = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    RSTN = 1'b1;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h1234_5678;
    tick();
    mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
    chk("rst_late_rvld", 32'(lsu_mem_rvld), 32'h0);
    chk("rst_late_wen",  32'(wb_rd_wen),    32'h0);
    chk("rst_late_busy", 32'(lsu_busy),     32'h0);
    $display("reset mid-WAIT abandons load");
    tick();

`ifdef LSU_MISALIGN_TRAP_EN
    alu_vld = 1'b1; alu_LS = 4'hA; alu_rd = 5'd10; alu_rd_wen = 1'b1; alu_out = 32'h0000_1002;
    tick();
    idle_inputs();
    chk("mis_w_req",  32'(mem_if.mem_req), 32'h0);
    chk("mis_w_flag", 32'(lsu_misalign),   32'h1);
    chk("mis_w_wen",  32'(wb_rd_wen),      32'h0);
    chk("mis_w_rvld", 32'(lsu_mem_rvld),   32'h0);
    chk("mis_w_busy", 32'(lsu_busy),       32'h0);
    tick();
    chk("mis_w_pulse", 32'(lsu_misalign),   32'h0);
    chk("mis_w_req2",  32'(mem_if.mem_req), 32'h0);
    $display("mis   LW 0x1002 trapped");
    alu_vld = 1'b1; alu_LS = 4'hD; alu_rs2_data = 32'h1111_2222; alu_out = 32'h0000_1001;
    tick();
    idle_inputs();
    chk("mis_sh_req",  32'(mem_if.mem_req), 32'h0);
    chk("mis_sh_flag", 32'(lsu_misalign),   32'h1);
    tick();
    chk("mis_sh_pulse", 32'(lsu_misalign), 32'h0);
    $display("mis   SH 0x1001 trapped");
`else
    do_load("lw_mis", 2'b10, 1'b0, 32'h0000_1002, 5'd10, 0, 32'h1122_3344, 32'h0000_1000, 32'h1122_3344);
    chk("nomis_flag", 32'(lsu_misalign), 32'h0);
    do_load("lh_mis", 2'b01, 1'b0, 32'h0000_1003, 5'd11, 0, 32'h80FF_FF7F, 32'h0000_1000, 32'hFFFF_80FF);
    do_store("sw_mis", 2'b10, 32'h0000_3003, 32'hCAFE_F00D, 0, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D);
    chk("nomis_flag2", 32'(lsu_misalign), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
